svnet_reg_fifo_mp: RTL and testbench
====================================

# svnet_reg_fifo_mp

Multi-lane register FIFO: up to LANES words written and up to LANES words read per clock, with a circular register array, an almost-full threshold, flush, and sticky overflow/underflow error flags. It sits between SVNet pipeline stages of unequal throughput, for example a convolution engine emitting several results per cycle feeding a narrower or wider consumer. It replaces the single-word register FIFO wherever a stage must move more than one word per cycle.

## Interface
- WIDTH, 1, bits per word
- DEPTH, 4, storage entries; any integer ≥ 1, not necessarily a power of two
- LANES, 1, maximum words written and maximum words read per cycle; 1 ≤ LANES ≤ DEPTH
- AFULL, DEPTH-1, almost_full threshold in words; 0 ≤ AFULL ≤ DEPTH
- Derived: SW = $clog2(DEPTH)+1 (space width), CW = $clog2(LANES)+1 (count width)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  empty the FIFO this cycle
- free_space  out  SW  DEPTH - used words
- write_count  in  CW  words to push this cycle; 0 = no write
- write_data  in  LANES×WIDTH  lane i holds the i-th word pushed; lanes ≥ write_count ignored
- used_space  out  SW  stored words
- read_data  out  LANES×WIDTH  lane i = i-th oldest entry; valid only for i < used_space
- read_count  in  CW  words to pop this cycle; 0 = no read
- almost_full  out  1  used_space ≥ AFULL
- overflow  out  1  sticky; set by a rejected write
- underflow  out  1  sticky; set by a rejected read

## Operation
- Storage: DEPTH×WIDTH registers, head pointer (oldest entry) and tail pointer (next free entry), each range 0..DEPTH-1, plus a count register of SW bits. Entries are not shifted.
- Pointer arithmetic is modulo DEPTH: ptr + n ≥ DEPTH wraps to ptr + n - DEPTH. n ≤ LANES ≤ DEPTH, so one conditional subtract is sufficient. No power-of-two masking is allowed.
- Write acceptance: accepted iff write_count ≤ free_space. free_space is the registered value, with no credit for a same-cycle read.
  - On accept, lane i writes entry (tail+i) mod DEPTH for i < write_count, and tail advances by write_count.
  - On reject, the entire write is dropped with no partial write, and overflow sets.
- Read acceptance: accepted iff read_count ≤ used_space. used_space is the registered value, with no credit for a same-cycle write.
  - On accept, head advances by read_count.
  - On reject, the read is dropped and underflow sets.
- Count update: count_next = count + accepted write_count - accepted read_count. This never exceeds DEPTH or goes below 0.
- read_data lane i is driven combinationally from entry (head+i) mod DEPTH. Lanes with i ≥ used_space present stale storage; consumers ignore them.
- almost_full and free_space are decoded from the count register.
- Flush:
  - Sets head = tail = 0 and count = 0.
  - Overrides any write or read in the same cycle; that write and read are discarded.
  - Does not set overflow or underflow, and does not clear them.
  - Does not clear the storage contents.
- Sticky flags clear only on rst.
- Reset values:
  - head = tail = count = 0, storage = 0.
  - free_space = DEPTH, used_space = 0, read_data = 0.
  - almost_full = (AFULL == 0), overflow = underflow = 0.
  - rst overrides flush, write and read.
- Simulation assertions (disabled during rst):
  - write_count ≤ LANES, read_count ≤ LANES.
  - write_count ≤ free_space, read_count ≤ used_space. These flag bench misuse; the RTL still applies the reject rule above.

## Timing
- Write-to-read latency is 1 cycle. A word accepted at edge N appears on read_data, and in used_space, after edge N.
- Read-to-read: a pop at edge N exposes the next entries on read_data immediately after edge N, and back-to-back full-rate pops are allowed.
- Status outputs are registered-state decodes. There is no combinational path from write_count or read_count to any output.
- read_data has a combinational path only from the head pointer and storage (a mux of DEPTH:1 per lane).
- Simultaneous write and read on a full FIFO: only write_count = 0 is accepted. The read proceeds, and any nonzero write is rejected with overflow set.
- Simultaneous write and read on an empty FIFO: the read is rejected if read_count > 0, and the write proceeds.
- rst asserted mid-stream takes effect at the next edge. All in-flight data is lost and the outputs take their reset values after that edge.

## Test plan
- Reset/idle, DEPTH=4, LANES=2, AFULL=3: hold rst 2 cycles then release -> free_space=4, used_space=0, almost_full=0, overflow=underflow=0, read_data=0.
- Multi-lane fill and drain with wrap, DEPTH=5, LANES=2:
  - Write pairs {1,2},{3,4} -> used_space=4.
  - Read 2 -> read_data lane0=3, lane1=4.
  - Write {5,6},{7} -> pointers wrap past index 4; reads return 3,4,5,6,7 in order; final used_space=0.
- Overflow reject, DEPTH=4, LANES=2, holding 3 words: write_count=2 -> nothing stored, used_space stays 3, overflow=1 and remains 1 after a later valid write.
- Underflow reject, empty FIFO: read_count=1 -> used_space stays 0, underflow=1. In the same cycle, write_count=1 data 0xA is still accepted -> used_space=1, lane0=0xA.
- Simultaneous write and read at full, DEPTH=4, LANES=2, full: read_count=2 with write_count=2 -> write rejected, overflow=1, used_space=2.
- Flush priority, 3 words stored: flush with write_count=1 and read_count=1 -> used_space=0, free_space=4, flags unchanged. Next write {0x55} -> read_data lane0=0x55 one cycle later.

Source files
------------

// File: rtl/svnet_reg_fifo_mp.sv
// Multi-lane register FIFO: up to LANES words pushed and popped per clock.
// Circular storage with modulo-DEPTH head/tail pointers (any DEPTH >= 1),
// almost-full threshold, flush, and sticky overflow/underflow flags.
module svnet_reg_fifo_mp #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int LANES = 1,
  parameter int AFULL = DEPTH - 1,
  localparam int SW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(LANES) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  output logic [SW-1:0]          free_space,
  input  logic [CW-1:0]          write_count,
  input  logic [LANES*WIDTH-1:0] write_data,
  output logic [SW-1:0]          used_space,
  output logic [LANES*WIDTH-1:0] read_data,
  input  logic [CW-1:0]          read_count,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [SW-1:0]    count;

  logic             wr_ok;
  logic             rd_ok;
  logic [SW-1:0]    wc_ext;
  logic [SW-1:0]    rc_ext;
  logic [PW-1:0]    head_adv;
  logic [PW-1:0]    tail_adv;
  logic [PW-1:0]    wr_idx [LANES];
  logic [PW-1:0]    rd_idx [LANES];

  // ptr + n never exceeds 2*DEPTH-1, so a single conditional subtract wraps it
  function automatic logic [PW-1:0] wrap(input logic [PW:0] sum);
    if (sum >= (PW+1)'(DEPTH))
      return PW'(sum - (PW+1)'(DEPTH));
    else
      return PW'(sum);
  endfunction

  assign used_space = count;
  assign free_space = SW'(DEPTH) - count;

  // almost_full decoded from the count register only
  generate
    if (AFULL == 0) begin : g_af_always
      assign almost_full = 1'b1;
    end else begin : g_af_cmp
      assign almost_full = (count >= SW'(AFULL));
    end
  endgenerate

  // Acceptance decisions, advanced pointers and per-lane entry indices
  always_comb begin
    wc_ext   = SW'(write_count);
    rc_ext   = SW'(read_count);
    wr_ok    = (wc_ext <= free_space);
    rd_ok    = (rc_ext <= count);
    tail_adv = wrap((PW+1)'(tail) + (PW+1)'(write_count));
    head_adv = wrap((PW+1)'(head) + (PW+1)'(read_count));
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_idx[i] = wrap((PW+1)'(tail) + (PW+1)'(i));
      rd_idx[i] = wrap((PW+1)'(head) + (PW+1)'(i));
    end
  end

  // Read lanes present the oldest entries straight from storage
  always_comb begin
    read_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      read_data[i*WIDTH +: WIDTH] = mem[rd_idx[i]];
    end
  end

  // Pointer, count and sticky flag update; flush overrides push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) tail <= tail_adv;
      else       overflow <= 1'b1;
      if (rd_ok) head <= head_adv;
      else       underflow <= 1'b1;
      count <= count + (wr_ok ? wc_ext : '0) - (rd_ok ? rc_ext : '0);
    end
  end

  // Storage write: accepted lanes land at consecutive entries from tail
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PW'(i)] <= '0;
      end
    end else if (!flush && wr_ok) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (CW'(i) < write_count)
          mem[wr_idx[i]] <= write_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Usage checks; over-capacity requests are still rejected by the logic above
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (write_count <= CW'(LANES));
      assert (read_count <= CW'(LANES));
      assert (wr_ok) else $warning("write_count exceeds free_space");
      assert (rd_ok) else $warning("read_count exceeds used_space");
    end
  end

endmodule

// File: tb/tb_svnet_reg_fifo_mp.sv
// Directed bench for svnet_reg_fifo_mp: two instances (DEPTH=4 and DEPTH=5,
// both LANES=2, WIDTH=8) driven with hand-computed vectors.
module tb_svnet_reg_fifo_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=4, LANES=2, AFULL=3
  logic        f4;
  logic [1:0]  wc4, rc4;
  logic [15:0] wd4, rd4;
  logic [2:0]  fs4, us4;
  logic        af4, ov4, un4;

  // DEPTH=5, LANES=2, AFULL=4 (default)
  logic        f5;
  logic [1:0]  wc5, rc5;
  logic [15:0] wd5, rd5;
  logic [3:0]  fs5, us5;
  logic        af5, ov5, un5;

  int checks = 0;
  int fails  = 0;

  svnet_reg_fifo_mp #(.WIDTH(8), .DEPTH(4), .LANES(2), .AFULL(3)) u_dut4 (
    .clk(clk), .rst(rst), .flush(f4), .free_space(fs4),
    .write_count(wc4), .write_data(wd4), .used_space(us4),
    .read_data(rd4), .read_count(rc4), .almost_full(af4),
    .overflow(ov4), .underflow(un4)
  );

  svnet_reg_fifo_mp #(.WIDTH(8), .DEPTH(5), .LANES(2)) u_dut5 (
    .clk(clk), .rst(rst), .flush(f5), .free_space(fs5),
    .write_count(wc5), .write_data(wd5), .used_space(us5),
    .read_data(rd5), .read_count(rc5), .almost_full(af5),
    .overflow(ov5), .underflow(un5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step4(input logic f, input logic [1:0] wc, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] rc);
    f4 = f; wc4 = wc; wd4 = {d1, d0}; rc4 = rc;
    @(posedge clk); #1;
    f4 = 1'b0; wc4 = '0; wd4 = '0; rc4 = '0;
  endtask

  task automatic step5(input logic [1:0] wc, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] rc);
    wc5 = wc; wd5 = {d1, d0}; rc5 = rc;
    @(posedge clk); #1;
    wc5 = '0; wd5 = '0; rc5 = '0;
  endtask

  initial begin
    rst = 1'b1;
    f4 = 1'b0; wc4 = '0; wd4 = '0; rc4 = '0;
    f5 = 1'b0; wc5 = '0; wd5 = '0; rc5 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle
    check("rst_free4",  fs4, 4);
    check("rst_used4",  us4, 0);
    check("rst_af4",    af4, 0);
    check("rst_ov4",    ov4, 0);
    check("rst_un4",    un4, 0);
    check("rst_rdata4", rd4, 16'h0000);
    check("rst_free5",  fs5, 5);
    check("rst_used5",  us5, 0);

    // Fill to 3 words, then a rejected 2-word write
    step4(0, 2, 8'h01, 8'h02, 0);
    step4(0, 1, 8'h03, 8'h00, 0);
    check("fill3_used", us4, 3);
    check("fill3_free", fs4, 1);
    check("fill3_af",   af4, 1);
    step4(0, 2, 8'h08, 8'h09, 0);
    check("ovf_used",   us4, 3);
    check("ovf_flag",   ov4, 1);
    check("ovf_rdata",  rd4, 16'h0201);
    step4(0, 1, 8'h04, 8'h00, 0);
    check("ovf_sticky", ov4, 1);
    check("full_used",  us4, 4);
    check("full_free",  fs4, 0);

    // Full: read 2 with write 2 -> read proceeds, write rejected
    step4(0, 2, 8'h0E, 8'h0F, 2);
    check("fullrw_used",  us4, 2);
    check("fullrw_ov",    ov4, 1);
    check("fullrw_un",    un4, 0);
    check("fullrw_rdata", rd4, 16'h0403);

    // Flush with 3 stored overrides write and read
    step4(0, 1, 8'h05, 8'h00, 0);
    check("preflush_used", us4, 3);
    step4(1, 1, 8'h77, 8'h00, 1);
    check("flush_used", us4, 0);
    check("flush_free", fs4, 4);
    check("flush_af",   af4, 0);
    check("flush_ov",   ov4, 1);
    check("flush_un",   un4, 0);
    step4(0, 1, 8'h55, 8'h00, 0);
    check("postflush_used",  us4, 1);
    check("postflush_lane0", rd4[7:0], 8'h55);

    // Underflow on empty with concurrent write
    step4(0, 0, 8'h00, 8'h00, 1);
    check("drain_used", us4, 0);
    step4(0, 1, 8'h0A, 8'h00, 1);
    check("unf_flag",  un4, 1);
    check("unf_used",  us4, 1);
    check("unf_lane0", rd4[7:0], 8'h0A);
    step4(0, 0, 8'h00, 8'h00, 1);
    check("unf_sticky", un4, 1);
    check("unf_drain",  us4, 0);

    // Multi-lane fill/drain with wrap on DEPTH=5
    step5(2, 8'h01, 8'h02, 0);
    step5(2, 8'h03, 8'h04, 0);
    check("w5_used",  us5, 4);
    check("w5_rdata", rd5, 16'h0201);
    step5(0, 8'h00, 8'h00, 2);
    check("r5_rdata", rd5, 16'h0403);
    check("r5_used",  us5, 2);
    step5(2, 8'h05, 8'h06, 0);
    step5(1, 8'h07, 8'h00, 0);
    check("wrap_used", us5, 5);
    check("wrap_free", fs5, 0);
    check("wrap_af",   af5, 1);
    check("wrap_ov",   ov5, 0);
    step5(0, 8'h00, 8'h00, 2);
    check("wrap_rd56",  rd5, 16'h0605);
    check("wrap_used3", us5, 3);
    step5(0, 8'h00, 8'h00, 2);
    check("wrap_rd7",   rd5[7:0], 8'h07);
    check("wrap_used1", us5, 1);
    step5(0, 8'h00, 8'h00, 1);
    check("wrap_empty", us5, 0);
    check("wrap_free5", fs5, 5);
    check("wrap_un",    un5, 0);

    // Mid-stream reset clears flags, count and storage
    step4(0, 2, 8'h11, 8'h22, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_used",  us4, 0);
    check("rst2_free",  fs4, 4);
    check("rst2_ov",    ov4, 0);
    check("rst2_un",    un4, 0);
    check("rst2_rdata", rd4, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
